ex_mdu: RTL

Parametrised multiply/divide unit for the RV32M extension, sitting beside the single-cycle ALU in the EX stage. It accepts one M-type operation (opcode R_M, funct7 = 0000001) from EX, stalls the front end through a hold request while it computes, and returns a one-cycle result write-back to the register file. Multiply takes a fixed short latency; divide/remainder iterates one quotient bit per cycle.

---
 rtl/ex_mdu_pkg.sv | 31 +++
 rtl/mdu_div_iter.sv | 72 +++++++
 rtl/ex_mdu.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared RV32M constants and decode helpers for the EX-stage multiply/divide unit.
package ex_mdu_pkg;

  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_W   = 7;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [FUNCT3_W-1:0] INST_MUL    = 3'b000;
  localparam logic [FUNCT3_W-1:0] INST_MULH   = 3'b001;
  localparam logic [FUNCT3_W-1:0] INST_MULHSU = 3'b010;
  localparam logic [FUNCT3_W-1:0] INST_MULHU  = 3'b011;
  localparam logic [FUNCT3_W-1:0] INST_DIV    = 3'b100;
  localparam logic [FUNCT3_W-1:0] INST_DIVU   = 3'b101;
  localparam logic [FUNCT3_W-1:0] INST_REM    = 3'b110;
  localparam logic [FUNCT3_W-1:0] INST_REMU   = 3'b111;

  localparam logic [FUNCT7_W-1:0] INST_FUNCT7_M = 7'b0000001;

  function automatic logic is_div_op(input logic [FUNCT3_W-1:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_rem_op(input logic [FUNCT3_W-1:0] f3);
    return f3[1];
  endfunction

  function automatic logic is_signed_div(input logic [FUNCT3_W-1:0] f3);
    return ~f3[0];
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Unsigned restoring divider core: one quotient bit per cycle for XLEN cycles after start.
module mdu_div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic             busy_q, busy_d;
  logic             done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  quot_d, rem_d;
  logic [XLEN:0]    shifted, trial;

  // Quotient shifts out of quot_o into the partial remainder; a non-negative trial keeps the subtraction.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    quot_d  = quot_o;
    rem_d   = rem_o;
    done_d  = 1'b0;
    shifted = {rem_o, quot_o[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      dvs_d  = divisor_i;
      quot_d = dividend_i;
      rem_d  = '0;
    end else if (busy_q) begin
      rem_d  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      quot_d = {quot_o[XLEN-2:0], ~trial[XLEN]};
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(XLEN-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvs_q  <= '0;
      quot_o <= '0;
      rem_o  <= '0;
      done_o <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dvs_q  <= dvs_d;
      quot_o <= quot_d;
      rem_o  <= rem_d;
      done_o <= done_d;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// RV32M multiply/divide unit beside the EX-stage ALU; stalls the front end while busy.
// Divide support is built only when MDU_DIV_EN is defined; otherwise divide ops raise illegal_o.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [FUNCT3_W-1:0]   funct3_i,
  input  logic [XLEN-1:0]       op1_i,
  input  logic [XLEN-1:0]       op2_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  flush_i,
  output logic                  hold_flag_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_wen_o,
  output logic                  illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [XLEN-1:0]       op1_q, op1_d, op2_q, op2_d;
  logic [FUNCT3_W-1:0]   funct3_q, funct3_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                  done_d, wen_d, ill_d;
  logic [XLEN-1:0]       rd_data_d;
  logic [REG_ADDR_W-1:0] rd_addr_out_d;
  logic                  fin;

  // Multiplier: operands extended to 2*XLEN so one unsigned product covers all signedness mixes.
  logic                  a_sgn, b_sgn;
  logic [2*XLEN-1:0]     mul_a, mul_b, prod;

  always_comb begin
    a_sgn = ((funct3_q == INST_MULH) || (funct3_q == INST_MULHSU)) & op1_q[XLEN-1];
    b_sgn = (funct3_q == INST_MULH) & op2_q[XLEN-1];
    mul_a = {{XLEN{a_sgn}}, op1_q};
    mul_b = {{XLEN{b_sgn}}, op2_q};
    prod  = mul_a * mul_b;
  end

`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            div_run_q, div_run_d;
  logic            div_start_c;
  logic            div_done;
  logic [XLEN-1:0] div_quot, div_rem;
  logic            div_sgn, div_rem_op, op1_neg, op2_neg;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] dvd_mag, dvs_mag, q_fix, r_fix;

  // Sign handling and special cases live here; the core only sees magnitudes.
  always_comb begin
    div_sgn     = is_signed_div(funct3_q);
    div_rem_op  = is_rem_op(funct3_q);
    op1_neg     = div_sgn & op1_q[XLEN-1];
    op2_neg     = div_sgn & op2_q[XLEN-1];
    dvd_mag     = op1_neg ? -op1_q : op1_q;
    dvs_mag     = op2_neg ? -op2_q : op2_q;
    div_by_zero = (op2_q == '0);
    div_ovf     = div_sgn && (op1_q == MIN_NEG) && (op2_q == '1);
    q_fix       = (op1_neg ^ op2_neg) ? -div_quot : div_quot;
    r_fix       = op1_neg ? -div_rem : div_rem;
  end

  mdu_div_iter #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start_c),
    .abort_i    (flush_i),
    .dividend_i (dvd_mag),
    .divisor_i  (dvs_mag),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );
`endif

  assign hold_flag_o = ((state_q == S_IDLE) && start_i) || (state_q == S_MUL)
`ifdef MDU_DIV_EN
                       || (state_q == S_DIV)
`endif
                       ;

  // Next-state and registered-output logic; flush overrides everything at the end.
  always_comb begin
    state_d       = state_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    funct3_d      = funct3_q;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_o;
    rd_addr_out_d = rd_addr_o;
    done_d        = 1'b0;
    wen_d         = 1'b0;
    ill_d         = 1'b0;
    fin           = 1'b0;
`ifdef MDU_DIV_EN
    div_run_d     = div_run_q;
    div_start_c   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op1_d     = op1_i;
          op2_d     = op2_i;
          funct3_d  = funct3_i;
          rd_addr_d = rd_addr_i;
          if (is_div_op(funct3_i)) begin
`ifdef MDU_DIV_EN
            state_d   = S_DIV;
            div_run_d = 1'b0;
`else
            ill_d     = 1'b1;
`endif
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        rd_data_d = (funct3_q == INST_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        fin       = 1'b1;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        if (!div_run_q) begin
          if (div_by_zero) begin
            rd_data_d = div_rem_op ? op1_q : '1;
            fin       = 1'b1;
          end else if (div_ovf) begin
            rd_data_d = div_rem_op ? '0 : op1_q;
            fin       = 1'b1;
          end else begin
            div_start_c = 1'b1;
            div_run_d   = 1'b1;
          end
        end else if (div_done) begin
          rd_data_d = div_rem_op ? r_fix : q_fix;
          div_run_d = 1'b0;
          fin       = 1'b1;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (fin) begin
      state_d       = S_DONE;
      done_d        = 1'b1;
      wen_d         = (rd_addr_q != '0);
      rd_addr_out_d = rd_addr_q;
    end
    if (flush_i) begin
      state_d       = S_IDLE;
      rd_data_d     = rd_data_o;
      rd_addr_out_d = rd_addr_o;
      done_d        = 1'b0;
      wen_d         = 1'b0;
      ill_d         = 1'b0;
`ifdef MDU_DIV_EN
      div_run_d     = 1'b0;
      div_start_c   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      funct3_q  <= '0;
      rd_addr_q <= '0;
      rd_data_o <= '0;
      rd_addr_o <= '0;
      done_o    <= 1'b0;
      rd_wen_o  <= 1'b0;
      illegal_o <= 1'b0;
`ifdef MDU_DIV_EN
      div_run_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      funct3_q  <= funct3_d;
      rd_addr_q <= rd_addr_d;
      rd_data_o <= rd_data_d;
      rd_addr_o <= rd_addr_out_d;
      done_o    <= done_d;
      rd_wen_o  <= wen_d;
      illegal_o <= ill_d;
`ifdef MDU_DIV_EN
      div_run_q <= div_run_d;
`endif
    end
  end

endmodule
